// File: rtl/prefill_fifo_bank_pkg.sv
// ---------------------------------------------------------------------------
// prefill_fifo_bank_pkg
// Shared types and constants for the prefill-gated FIFO bank.
//   state_t        : reader state (IDLE, PREFILL, STREAM)
//   UNDERRUN_CNT_W : width of the saturating underrun counter
//   sat_inc()      : saturating increment for that counter
// ---------------------------------------------------------------------------
package prefill_fifo_bank_pkg;

    localparam int UNDERRUN_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        STREAM  = 2'd2
    } state_t;

    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(
        input logic [UNDERRUN_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/prefill_fifo_bank_if.sv
// ---------------------------------------------------------------------------
// prefill_fifo_bank_if
// Groups the producer write bus, the reader control and the ready/valid
// output stream of the FIFO bank. Clock and reset stay plain ports.
//   master : producer / consumer side (drives writes, flush, reader_en, out_ready)
//   slave  : the FIFO bank (drives status flags and the output stream)
// ---------------------------------------------------------------------------
interface prefill_fifo_bank_if #(
    parameter int NUM_FIFO   = 4,
    parameter int DATA_WIDTH = 16
);
    import prefill_fifo_bank_pkg::*;

    localparam int CH_W = $clog2(NUM_FIFO);

    logic                           flush;
    logic [NUM_FIFO-1:0]            wr_en;
    logic [NUM_FIFO*DATA_WIDTH-1:0] wr_data;
    logic [NUM_FIFO-1:0]            full;
    logic [NUM_FIFO-1:0]            empty;
    logic                           reader_en;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [CH_W-1:0]                out_ch;
    logic [NUM_FIFO-1:0]            overflow;
    logic [UNDERRUN_CNT_W-1:0]      underrun_cnt;
    logic                           streaming;

    modport master (
        output flush, wr_en, wr_data, reader_en, out_ready,
        input  full, empty, out_valid, out_data, out_ch, overflow,
               underrun_cnt, streaming
    );

    modport slave (
        input  flush, wr_en, wr_data, reader_en, out_ready,
        output full, empty, out_valid, out_data, out_ch, overflow,
               underrun_cnt, streaming
    );

endinterface

// File: rtl/prefill_fifo_bank_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. Pointers carry one extra wrap
// bit so count = wr_ptr - rd_ptr distinguishes full from empty.
//   clk, rstn : clock, asynchronous active-low reset
//   flush     : synchronous clear of both pointers
//   wr_en     : store wr_data unless full
//   rd_en     : advance past the head word unless empty
//   rd_data   : current head word (valid while !empty)
//   count     : occupancy, full / empty derived from it
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter  int DATA_WIDTH = 16,
    parameter  int FIFO_DEPTH = 32,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  wr_fire;
    logic                  rd_fire;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Both gates use the pre-edge flags: a write to a full FIFO is dropped
    // even when a read frees a slot in the same cycle.
    assign wr_fire = wr_en && !full && !flush;
    assign rd_fire = rd_en && !empty && !flush;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/prefill_fifo_bank.sv
// ---------------------------------------------------------------------------
// prefill_fifo_bank
// NUM_FIFO independent channel FIFOs drained by one round-robin reader.
// The reader waits until every channel holds at least PREFILL words, then
// streams channel 0,1,..,NUM_FIFO-1,0,.. onto a registered ready/valid port.
// Finding the current channel empty drops the reader back to PREFILL and
// bumps a saturating underrun counter; the channel pointer is kept so the
// order never skips.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : prefill_fifo_bank_if.slave
//               flush (sync clear), wr_en/wr_data (per channel), full/empty,
//               reader_en, out_valid/out_ready/out_data/out_ch,
//               overflow (sticky per channel), underrun_cnt, streaming
// ---------------------------------------------------------------------------
module prefill_fifo_bank #(
    parameter int NUM_FIFO   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int PREFILL    = 8
) (
    input logic                clk,
    input logic                rstn,
    prefill_fifo_bank_if.slave bus
);
    // The PREFILL parameter shares its name with a state literal, so the
    // package is imported item by item and that state is referenced scoped.
    import prefill_fifo_bank_pkg::state_t;
    import prefill_fifo_bank_pkg::IDLE;
    import prefill_fifo_bank_pkg::STREAM;
    import prefill_fifo_bank_pkg::UNDERRUN_CNT_W;
    import prefill_fifo_bank_pkg::sat_inc;

    localparam int CH_W  = $clog2(NUM_FIFO);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                    state_q;
    logic [CH_W-1:0]           ptr_q, ptr_d;
    logic                      out_valid_q;
    logic [DATA_WIDTH-1:0]     out_data_q;
    logic [CH_W-1:0]           out_ch_q;
    logic [NUM_FIFO-1:0]       overflow_q;
    logic [UNDERRUN_CNT_W-1:0] underrun_cnt_q, underrun_cnt_d;

    logic [DATA_WIDTH-1:0]     head_w   [NUM_FIFO];
    logic [CNT_W-1:0]          count_w  [NUM_FIFO];
    logic [NUM_FIFO-1:0]       full_w;
    logic [NUM_FIFO-1:0]       empty_w;
    logic [NUM_FIFO-1:0]       rd_en_w;
    logic [NUM_FIFO-1:0]       prefilled_w;
    logic                      slot_free_w;
    logic                      load_w;
    logic                      underrun_w;

    for (genvar j = 0; j < NUM_FIFO; j++) begin : g_fifo
        sync_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rstn    (rstn),
            .flush   (bus.flush),
            .wr_en   (bus.wr_en[j]),
            .wr_data (bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH]),
            .rd_en   (rd_en_w[j]),
            .rd_data (head_w[j]),
            .count   (count_w[j]),
            .full    (full_w[j]),
            .empty   (empty_w[j])
        );

        assign rd_en_w[j]     = load_w && (ptr_q == CH_W'(j));
        assign prefilled_w[j] = (count_w[j] >= CNT_W'(PREFILL));
    end

    // The output register can take a word when it is empty or being drained.
    assign slot_free_w = !out_valid_q || bus.out_ready;
    assign load_w      = (state_q == STREAM) && !empty_w[ptr_q] && slot_free_w;
    // A load that is blocked only by an empty current channel is an underrun.
    assign underrun_w  = (state_q == STREAM) && empty_w[ptr_q] && slot_free_w;

    assign ptr_d          = (ptr_q == CH_W'(NUM_FIFO - 1)) ? '0 : ptr_q + 1'b1;
    assign underrun_cnt_d = sat_inc(underrun_cnt_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_ch_q       <= '0;
            overflow_q     <= '0;
            underrun_cnt_q <= '0;
        end else if (bus.flush) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_ch_q       <= '0;
            overflow_q     <= '0;
            underrun_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_q | (bus.wr_en & full_w);

            // A pending word finishes its handshake whatever the state does.
            if (load_w) begin
                out_valid_q <= 1'b1;
                out_data_q  <= head_w[ptr_q];
                out_ch_q    <= ptr_q;
                ptr_q       <= ptr_d;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.reader_en) state_q <= prefill_fifo_bank_pkg::PREFILL;
                end
                prefill_fifo_bank_pkg::PREFILL: begin
                    if (!bus.reader_en)      state_q <= IDLE;
                    else if (&prefilled_w)   state_q <= STREAM;
                end
                STREAM: begin
                    if (!bus.reader_en) begin
                        state_q <= IDLE;
                    end else if (underrun_w) begin
                        state_q        <= prefill_fifo_bank_pkg::PREFILL;
                        underrun_cnt_q <= underrun_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_ch       = out_ch_q;
    assign bus.overflow     = overflow_q;
    assign bus.underrun_cnt = underrun_cnt_q;
    assign bus.streaming    = (state_q == STREAM);

endmodule

// File: doc/prefill_fifo_bank.md
# prefill_fifo_bank

Single-clock bank of NUM_FIFO independent FIFOs with a prefill-gated round-robin reader, replacing the separate writer/reader/FIFO trio in the convolution accelerator input path. Producers push per-channel data. Once every channel holds at least PREFILL words, the reader streams words channel 0,1,…,NUM_FIFO-1,0,… onto one ready/valid output. An underrun sends the reader back to prefill; overflow and underrun events are recorded.

## Interface
Parameters:
- NUM_FIFO, 4, channel count (≥2)
- DATA_WIDTH, 16, word width
- FIFO_DEPTH, 32, words per channel (power of 2, ≥4)
- PREFILL, 8, per-channel level required to start or resume streaming (1..FIFO_DEPTH)

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous clear of all FIFOs, reader state and sticky flags
- wr_en  in  NUM_FIFO  per-channel write strobe
- wr_data  in  NUM_FIFO*DATA_WIDTH  channel j at bits [j*DATA_WIDTH +: DATA_WIDTH]
- full  out  NUM_FIFO  channel count == FIFO_DEPTH
- empty  out  NUM_FIFO  channel count == 0
- reader_en  in  1  enables leaving IDLE
- out_valid  out  1  output word valid (registered)
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH  output word (registered)
- out_ch  out  $clog2(NUM_FIFO)  source channel of out_data
- overflow  out  NUM_FIFO  sticky: write attempted while full
- underrun_cnt  out  16  saturating count of STREAM→PREFILL fallbacks
- streaming  out  1  state == STREAM

## Operation
- Reset (rstn=0) or flush=1: all counts and pointers 0, so full=0 and empty=all-ones. Also out_valid=0, out_data=0, out_ch=0, overflow=0, underrun_cnt=0, streaming=0, ptr=0, state=IDLE. flush overrides every other input in that cycle.
- Write: a word is stored when wr_en[j] && !full[j]. full is the pre-edge value, so a write to a full channel is dropped even if a read of that channel occurs in the same cycle. A dropped write sets overflow[j].
- Pop from channel ptr ("load"): occurs when state==STREAM && !empty[ptr] && (!out_valid || out_ready). In the pop cycle out_data←head[ptr], out_ch←ptr, out_valid←1, ptr←(ptr+1) mod NUM_FIFO. A simultaneous write and pop on one channel leaves its count unchanged. A write to an empty channel cannot be popped in the same cycle.
- out_valid clears when out_ready && out_valid && no load occurs that cycle. out_data holds stable while out_valid && !out_ready.
- FSM:
  - IDLE: reader_en=1 → PREFILL.
  - PREFILL: reader_en=0 → IDLE; else if all counts ≥ PREFILL → STREAM.
  - STREAM: reader_en=0 → IDLE. Otherwise, if a load is possible apart from empty[ptr]=1 → PREFILL and underrun_cnt++ (saturates at 0xFFFF).
  - Leaving STREAM does not cancel a pending output word; it completes its handshake.
- ptr is retained across PREFILL and IDLE, so the channel order never skips.
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally. count = wr_ptr − rd_ptr.

## Timing
- Write at edge N: count, empty and full update at N+1. That word is poppable at edge N+1 at the earliest.
- PREFILL→STREAM transition happens on the edge where the condition is seen. The first load is on the next edge, and out_valid is high after it.
- Streaming throughput is 1 word/cycle when out_ready=1 and no channel runs empty.
- Underrun detection and the PREFILL transition take effect on the same edge. No word is emitted that cycle.
- Deasserting rstn mid-stream clears immediately (asynchronous). Flush takes effect on the next edge.

## Structure
- Package prefill_fifo_bank_pkg holds the state_t enum (IDLE, PREFILL, STREAM) and the UNDERRUN_CNT_W=16 constant.
- Sub-module sync_fifo is a single-clock FIFO (DATA_WIDTH, FIFO_DEPTH; ports wr_en, wr_data, rd_en, rd_data head (FWFT), count, full, empty, flush). It is instantiated NUM_FIFO times with a generate loop.
- The top level contains the FSM, ptr, output register and flags.

## Test plan
- Prefill gate: defaults; write 8 words into ch0–2 and 7 into ch3, reader_en=1 → remains PREFILL, out_valid=0. The 8th ch3 write → STREAM, then out_ch sequence 0,1,2,3,0…
- Round-robin data: ch j holds 16'hj000+k, out_ready=1 → out_data sequence 0000,1000,2000,3000,0001,… with 1 word per cycle.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream → out_data and out_ch stable, no count decrements beyond the held word, no word is lost after release.
- Underrun: stop writing ch2 after 8 words and stream → after ch2's 8th pop, the next ch2 turn gives PREFILL and underrun_cnt=1, ptr=2. Refilling every channel to ≥8 resumes with out_ch=2.
- Overflow: fill ch1 with 32 words, then write once more with out_ready=0 → full[1]=1, overflow=4'b0010, count stays 32, and the dropped word never appears.
- Flush/reset mid-stream: assert flush with out_valid=1 → next cycle empty=4'hF, out_valid=0, state IDLE, overflow=0. Repeat using rstn=0 asynchronously between edges → outputs clear without a clock edge.
